// File: rtl/xdomain_word_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : xdomain_word_tx_if
// Purpose  : Stream + toggle-handshake bundle for the word transmitter.
// Revision : 1.0
// ============================================================================
interface xdomain_word_tx_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 InValid_clkA;
  logic                 InReady_clkA;
  logic [WIDTH-1:0]     InData_clkA;
  logic                 ReqToggle_clkA;
  logic [WIDTH-1:0]     DataOut_clkA;
  logic                 AckToggle_async;
  logic                 Done_clkA;
  logic                 Busy_clkA;
  logic [CNT_WIDTH-1:0] SentCount_clkA;
  logic                 Timeout_clkA;
  logic                 ProtoErr_clkA;

  // Transmitter side.
  modport slave (
    input  InValid_clkA, InData_clkA, AckToggle_async,
    output InReady_clkA, ReqToggle_clkA, DataOut_clkA, Done_clkA,
           Busy_clkA, SentCount_clkA, Timeout_clkA, ProtoErr_clkA
  );

  // Upstream producer plus remote receiver.
  modport master (
    output InValid_clkA, InData_clkA, AckToggle_async,
    input  InReady_clkA, ReqToggle_clkA, DataOut_clkA, Done_clkA,
           Busy_clkA, SentCount_clkA, Timeout_clkA, ProtoErr_clkA
  );
endinterface
`default_nettype wire

// File: rtl/xdomain_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : xdomain_word_tx
// Purpose  : Source end of a two-phase toggle handshake carrying words
//            from clkA into a remote clock domain.
// Revision : 1.0
// ============================================================================
module xdomain_word_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_WIDTH   = 16
) (
  input  logic              clkA,
  input  logic              rst_clkA,
  xdomain_word_tx_if.slave  bus
);

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_ACK = 1'b1
  } state_t;

  state_t                 state_q,    state_d;
  logic [WIDTH-1:0]       hold_q,     hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   req_q,      req_d;
  logic [WIDTH-1:0]       data_q,     data_d;
  logic                   done_q,     done_d;
  logic [CNT_WIDTH-1:0]   sent_q,     sent_d;
  logic [TO_W-1:0]        to_cnt_q,   to_cnt_d;
  logic                   timeout_q,  timeout_d;
  logic                   proto_q,    proto_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;

  logic w_ack_s;
  logic w_in_ready;
  logic w_accept;
  logic w_launch;

  assign w_ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign w_in_ready = ~hold_full_q & ~rst_clkA;
  assign w_accept   = bus.InValid_clkA & w_in_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    req_d       = req_q;
    data_d      = data_q;
    done_d      = 1'b0;
    sent_d      = sent_q;
    to_cnt_d    = to_cnt_q;
    timeout_d   = timeout_q;
    proto_d     = proto_q;
    w_launch    = 1'b0;
    // Raw asynchronous ack goes straight into the first stage.
    ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], bus.AckToggle_async};

    case (state_q)
      S_IDLE: begin
        if (w_ack_s != req_q) begin
          proto_d = 1'b1;
        end
        if (hold_full_q) begin
          w_launch = 1'b1;
          state_d  = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (w_ack_s == req_q) begin
          done_d   = 1'b1;
          sent_d   = sent_q + CNT_WIDTH'(1);
          to_cnt_d = '0;
          if (hold_full_q) begin
            w_launch = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if ((TIMEOUT != 0) && (to_cnt_q != TO_LIMIT)) begin
          // Counter saturates at the limit; the flag stays set once reached.
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_d == TO_LIMIT) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_launch) begin
      data_d      = hold_q;
      req_d       = ~req_q;
      hold_full_d = 1'b0;
    end
    if (w_accept) begin
      hold_d      = bus.InData_clkA;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clkA) begin
    if (rst_clkA) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      req_q       <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      sent_q      <= '0;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      proto_q     <= 1'b0;
      ack_sync_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      req_q       <= req_d;
      data_q      <= data_d;
      done_q      <= done_d;
      sent_q      <= sent_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
      proto_q     <= proto_d;
      ack_sync_q  <= ack_sync_d;
    end
  end

  assign bus.InReady_clkA   = w_in_ready;
  assign bus.ReqToggle_clkA = req_q;
  assign bus.DataOut_clkA   = data_q;
  assign bus.Done_clkA      = done_q;
  assign bus.Busy_clkA      = (state_q == S_WAIT_ACK) | hold_full_q;
  assign bus.SentCount_clkA = sent_q;
  assign bus.Timeout_clkA   = timeout_q;
  assign bus.ProtoErr_clkA  = proto_q;

endmodule
`default_nettype wire

// File: tb/tb_xdomain_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_xdomain_word_tx
// Purpose  : Directed self-checking bench for xdomain_word_tx.
// Revision : 1.0
// ============================================================================
module tb_xdomain_word_tx;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 8;
  localparam int CNT_WIDTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xdomain_word_tx_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  xdomain_word_tx #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clkA(clk), .rst_clkA(rst), .bus(bus)
  );

  // Ack source: either driven directly, or by a remote model that
  // returns the request level about five cycles after it changes.
  logic auto_ack  = 1'b0;
  logic ack_cmd   = 1'b0;
  logic model_ack = 1'b0;
  int   ack_delay = 0;
  assign bus.AckToggle_async = auto_ack ? model_ack : ack_cmd;

  initial forever begin
    @(negedge clk);
    if (!auto_ack) begin
      model_ack = ack_cmd;
      ack_delay = 0;
    end else if (bus.ReqToggle_clkA != model_ack) begin
      if (ack_delay == 4) begin
        model_ack = bus.ReqToggle_clkA;
        ack_delay = 0;
      end else begin
        ack_delay++;
      end
    end
  end

  // Monitor: launched words, toggles, Done pulses, DataOut changes without a toggle.
  logic             prev_req  = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  int               toggles   = 0;
  int               dones     = 0;
  int               unstable  = 0;
  logic [WIDTH-1:0] launched[$];

  initial forever begin
    @(negedge clk);
    if (bus.ReqToggle_clkA != prev_req) begin
      toggles++;
      launched.push_back(bus.DataOut_clkA);
    end else if (bus.DataOut_clkA != prev_data) begin
      unstable++;
    end
    if (bus.Done_clkA) dones++;
    prev_req  = bus.ReqToggle_clkA;
    prev_data = bus.DataOut_clkA;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic saw_not_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    auto_ack = 1'b0;
    ack_cmd  = 1'b0;
    bus.InValid_clkA = 1'b0;
    bus.InData_clkA  = '0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Presents a word until accepted; returns at the negedge after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] w);
    logic ok;
    ok = 1'b0;
    bus.InValid_clkA = 1'b1;
    bus.InData_clkA  = w;
    for (int i = 0; i < 300; i++) begin
      ok = bus.InReady_clkA;
      if (!ok) saw_not_ready = 1'b1;
      @(negedge clk);
      if (ok) break;
    end
    if (!ok) check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_dones(input int base, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dones - base >= target) break;
      @(negedge clk);
    end
    check("dones_wait", 32'(dones - base), 32'(target));
  endtask

  int t_base, d_base, q_base, u_base;

  initial begin
    // Reset state
    step(2);
    check("ready_in_reset", 32'(bus.InReady_clkA), 32'd0);
    rst = 1'b0;
    step(1);
    check("rst_ready",   32'(bus.InReady_clkA),   32'd1);
    check("rst_req",     32'(bus.ReqToggle_clkA), 32'd0);
    check("rst_data",    32'(bus.DataOut_clkA),   32'd0);
    check("rst_busy",    32'(bus.Busy_clkA),      32'd0);
    check("rst_done",    32'(bus.Done_clkA),      32'd0);
    check("rst_sent",    32'(bus.SentCount_clkA), 32'd0);
    check("rst_timeout", 32'(bus.Timeout_clkA),   32'd0);
    check("rst_proto",   32'(bus.ProtoErr_clkA),  32'd0);

    // Single word 0xA5
    do_reset();
    send(8'hA5);
    bus.InValid_clkA = 1'b0;
    check("t1_held_busy",  32'(bus.Busy_clkA),      32'd1);
    check("t1_held_ready", 32'(bus.InReady_clkA),   32'd0);
    check("t1_req_before", 32'(bus.ReqToggle_clkA), 32'd0);
    step(1);
    check("t1_data", 32'(bus.DataOut_clkA),   32'hA5);
    check("t1_req",  32'(bus.ReqToggle_clkA), 32'd1);
    check("t1_busy", 32'(bus.Busy_clkA),      32'd1);
    ack_cmd = 1'b1;
    step(2);
    check("t1_done_early", 32'(bus.Done_clkA), 32'd0);
    step(1);
    check("t1_done", 32'(bus.Done_clkA),      32'd1);
    check("t1_sent", 32'(bus.SentCount_clkA), 32'd1);
    step(1);
    check("t1_done_once", 32'(bus.Done_clkA),     32'd0);
    check("t1_idle_busy", 32'(bus.Busy_clkA),     32'd0);
    check("t1_proto",     32'(bus.ProtoErr_clkA), 32'd0);

    // Stream 0x01..0x03 with remote model acking
    do_reset();
    auto_ack = 1'b1;
    step(1);
    t_base = toggles; u_base = unstable; q_base = launched.size(); d_base = dones;
    saw_not_ready = 1'b0;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    bus.InValid_clkA = 1'b0;
    wait_dones(d_base, 3, 200);
    step(10);
    check("t2_sent",     32'(bus.SentCount_clkA), 32'd3);
    check("t2_toggles",  32'(toggles - t_base),   32'd3);
    check("t2_backpres", 32'(saw_not_ready),      32'd1);
    check("t2_stable",   32'(unstable - u_base),  32'd0);
    check("t2_w0", 32'(launched[q_base]),     32'h01);
    check("t2_w1", 32'(launched[q_base + 1]), 32'h02);
    check("t2_w2", 32'(launched[q_base + 2]), 32'h03);
    check("t2_busy",  32'(bus.Busy_clkA),     32'd0);
    check("t2_proto", 32'(bus.ProtoErr_clkA), 32'd0);

    // Timeout after 8 WAIT_ACK cycles, late ack still completes
    do_reset();
    send(8'h5A);
    bus.InValid_clkA = 1'b0;
    step(1);
    check("t3_req", 32'(bus.ReqToggle_clkA), 32'd1);
    step(7);
    check("t3_timeout_early", 32'(bus.Timeout_clkA), 32'd0);
    step(1);
    check("t3_timeout", 32'(bus.Timeout_clkA),   32'd1);
    check("t3_data",    32'(bus.DataOut_clkA),   32'h5A);
    check("t3_req_hold", 32'(bus.ReqToggle_clkA), 32'd1);
    ack_cmd = 1'b1;
    step(3);
    check("t3_done",   32'(bus.Done_clkA),      32'd1);
    check("t3_sent",   32'(bus.SentCount_clkA), 32'd1);
    check("t3_sticky", 32'(bus.Timeout_clkA),   32'd1);

    // Unsolicited ack in IDLE
    do_reset();
    ack_cmd = 1'b1;
    step(2);
    check("t4_proto_early", 32'(bus.ProtoErr_clkA), 32'd0);
    step(1);
    check("t4_proto", 32'(bus.ProtoErr_clkA),  32'd1);
    check("t4_req",   32'(bus.ReqToggle_clkA), 32'd0);

    // Reset mid-WAIT_ACK with hold full
    do_reset();
    send(8'h11);
    send(8'h22);
    bus.InValid_clkA = 1'b0;
    check("t5_busy",  32'(bus.Busy_clkA),    32'd1);
    check("t5_ready", 32'(bus.InReady_clkA), 32'd0);
    check("t5_data",  32'(bus.DataOut_clkA), 32'h11);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
    check("t5_req",   32'(bus.ReqToggle_clkA), 32'd0);
    check("t5_dout",  32'(bus.DataOut_clkA),   32'd0);
    check("t5_busy0", 32'(bus.Busy_clkA),      32'd0);
    check("t5_sent",  32'(bus.SentCount_clkA), 32'd0);
    check("t5_rdy1",  32'(bus.InReady_clkA),   32'd1);

    // 17 transfers with a 4-bit counter
    do_reset();
    auto_ack = 1'b1;
    step(1);
    d_base = dones;
    for (int i = 0; i < 17; i++) send(8'(i + 8'h40));
    bus.InValid_clkA = 1'b0;
    wait_dones(d_base, 17, 1000);
    step(10);
    check("t6_sent",  32'(bus.SentCount_clkA), 32'd1);
    check("t6_dones", 32'(dones - d_base),     32'd17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/xdomain_word_tx.md
Name: xdomain_word_tx

Overview:
Source-domain end of a two-phase toggle handshake for carrying multi-bit words into another clock domain. Accepts words from a local valid/ready stream. Drives a level-toggle request with a data bus held stable while the word is in flight. Synchronises the remote domain's acknowledge toggle and completes the transfer when it matches the request. The remote receiver (separate block) captures data on a request toggle edge and returns the toggle as acknowledge.

Parameters:
WIDTH, 8, data word width
SYNC_STAGES, 2, flops in acknowledge synchroniser (legal 2..4)
TIMEOUT, 1024, cycles in WAIT_ACK before sticky timeout flag; 0 disables
CNT_WIDTH, 16, width of completed-transfer counter

Ports:
clkA  input  1  sole clock
rst_clkA  input  1  synchronous active-high reset
InValid_clkA  input  1  upstream word valid
InReady_clkA  output  1  holding register free
InData_clkA  input  WIDTH  upstream word
ReqToggle_clkA  output  1  request level, flips once per launched word (registered)
DataOut_clkA  output  WIDTH  launched word, stable from toggle until ack (registered)
AckToggle_async  input  1  acknowledge level from remote domain, asynchronous
Done_clkA  output  1  one-cycle pulse per completed transfer
Busy_clkA  output  1  high in WAIT_ACK or holding register full
SentCount_clkA  output  CNT_WIDTH  completed transfers, wraps
Timeout_clkA  output  1  sticky: an ack wait exceeded TIMEOUT
ProtoErr_clkA  output  1  sticky: ack changed while IDLE

Behaviour:
- Reset (synchronous, all flops):
  - ReqToggle, DataOut, sync chain, SentCount, timeout counter, Timeout, ProtoErr, Done = 0.
  - Holding register empty; state IDLE.
  - InReady forced 0 while rst_clkA high.
  - Reset mid-transfer abandons the word. The remote end must be reset in the same event.
- Ack synchroniser:
  - SYNC_STAGES flops clocked by clkA. ack_s is the last stage.
  - No logic between AckToggle_async and the first flop.
- Upstream handshake:
  - InReady = ~hold_full (when not in reset).
  - InValid & InReady at an edge loads InData into hold; hold_full = 1.
  - InData may change freely when not accepted.
- State IDLE:
  - If hold_full at an edge: DataOut <= hold, ReqToggle <= ~ReqToggle, hold empties, go to WAIT_ACK.
  - Accept-to-toggle latency is 1 cycle: accept at edge N, launch at edge N+1.
  - Simultaneous launch and accept at the same edge: the new word goes into hold and hold stays full.
- State WAIT_ACK:
  - DataOut and ReqToggle are held constant.
  - Each cycle, timeout counter increments (saturating). When it reaches TIMEOUT and TIMEOUT != 0, Timeout sets. Waiting continues; no abort.
  - Completion occurs when ack_s == ReqToggle. At that edge:
    - Done pulses for 1 cycle (registered, visible the following cycle).
    - SentCount += 1, wrapping from 2^CNT_WIDTH-1 to 0.
    - Timeout counter clears.
  - Back-to-back: if hold_full at the completion edge, launch the next word at the same edge and stay in WAIT_ACK. Otherwise go to IDLE.
- ProtoErr: set in IDLE when ack_s != ReqToggle. Sticky until reset. No state change.
- Busy = (state == WAIT_ACK) | hold_full.
- Throughput: one word per (1 + SYNC_STAGES + remote latency) cycles at best.
- Holding capacity: one word in flight plus one held. Upstream sees back-pressure beyond that.

Test Plan:
- Reset, then InValid=1, InData=0xA5 for 1 cycle -> next cycle DataOut=0xA5, ReqToggle 0->1, Busy=1. Drive AckToggle_async=1 -> Done pulses exactly SYNC_STAGES+1 cycles later, SentCount=1, state IDLE.
- Feed 0x01,0x02,0x03 continuously with remote model acking after 5 cycles -> InReady drops while hold full. Words launched in order 0x01,0x02,0x03, each with exactly one toggle and DataOut stable between toggle and ack. SentCount=3.
- TIMEOUT=8, never ack -> Timeout sets after 8 WAIT_ACK cycles. DataOut/ReqToggle unchanged. A late ack still completes (Done pulse, SentCount=1), and Timeout stays 1.
- In IDLE, flip AckToggle_async without a request -> ProtoErr=1 after SYNC_STAGES+1 cycles. ReqToggle unchanged.
- Assert rst_clkA one cycle mid-WAIT_ACK with hold full -> all outputs return to reset values next cycle, hold empty, InReady=1 after rst deasserts.
- CNT_WIDTH=4, run 17 transfers -> SentCount reads 1. Done pulses counted = 17.
